// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM for a multicycle MIPS-style datapath.
// Moore machine: datapath controls are decoded from the state register, with
// mem_ready gating only the FETCH load strobes and the MEM_WRITE completion.
// Optional feature: define MULTICYCLE_CONTROL_JR_EN to add the JR state
// (R-type with funct 001000 jumps to register rs in three cycles).
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic [1:0] aluop,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_R_EXEC    = 4'd6,
        ST_R_WB      = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_JUMP      = 4'd9,
        ST_I_EXEC    = 4'd10,
`ifdef MULTICYCLE_CONTROL_JR_EN
        ST_I_WB      = 4'd11,
        ST_JR        = 4'd12
`else
        ST_I_WB      = 4'd11
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

`ifdef MULTICYCLE_CONTROL_JR_EN
    localparam logic [5:0] FN_JR    = 6'b001000;
`else
    // funct only matters for the JR path; fold it so it is not left dangling.
    logic w_unused_funct;
    assign w_unused_funct = ^funct;
`endif

    state_t r_state;
    logic   w_opcode_legal;

    assign state = r_state;

    // Classify the opcode held in the instruction register.
    always_comb begin
        w_opcode_legal = 1'b0;
        case (opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI: w_opcode_legal = 1'b1;
            default:                                              w_opcode_legal = 1'b0;
        endcase
    end

    // State register and next-state selection; reset wins over any pending wait.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            case (r_state)
                ST_FETCH:     if (mem_ready) r_state <= ST_DECODE;
                ST_DECODE: begin
                    case (opcode)
                        OP_RTYPE: begin
`ifdef MULTICYCLE_CONTROL_JR_EN
                            if (funct == FN_JR) r_state <= ST_JR;
                            else                r_state <= ST_R_EXEC;
`else
                            r_state <= ST_R_EXEC;
`endif
                        end
                        OP_LW, OP_SW:     r_state <= ST_MEM_ADDR;
                        OP_BEQ:           r_state <= ST_BRANCH;
                        OP_J:             r_state <= ST_JUMP;
                        OP_ADDI, OP_ORI:  r_state <= ST_I_EXEC;
                        default:          r_state <= ST_FETCH;
                    endcase
                end
                ST_MEM_ADDR:  r_state <= (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
                ST_MEM_READ:  if (mem_ready) r_state <= ST_MEM_WB;
                ST_MEM_WRITE: if (mem_ready) r_state <= ST_FETCH;
                ST_R_EXEC:    r_state <= ST_R_WB;
                ST_I_EXEC:    r_state <= ST_I_WB;
                // MEM_WB, R_WB, I_WB, BRANCH, JUMP, JR and unused codes 13-15
                default:      r_state <= ST_FETCH;
            endcase
        end
    end

    // Datapath control decode from the current state.
    always_comb begin
        // NOTE: every output gets a default before the case so no state path
        // leaves one unassigned, which would otherwise infer a latch.
        aluop         = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        case (r_state)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE: begin
                alu_src_b  = 2'b11;
                illegal_op = ~w_opcode_legal;
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            ST_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            ST_MEM_WRITE: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ready;
            end
            ST_R_EXEC: begin
                alu_src_a = 1'b1;
                aluop     = 2'b10;
            end
            ST_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                aluop         = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
            end
            ST_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
            end
            ST_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                aluop     = (opcode == OP_ORI) ? 2'b11 : 2'b00;
            end
            ST_I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
`ifdef MULTICYCLE_CONTROL_JR_EN
            ST_JR: begin
                pc_write   = 1'b1;
                pc_source  = 2'b11;
                instr_done = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven per-cycle check of multicycle_control
// outputs, plus instruction latency sequences with memory wait states.
// Honours MULTICYCLE_CONTROL_JR_EN for the jr expectations.
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic [1:0] aluop;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] state;
    logic       instr_done;
    logic       illegal_op;

    multicycle_control dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct         (funct),
        .mem_ready     (mem_ready),
        .aluop         (aluop),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .state         (state),
        .instr_done    (instr_done),
        .illegal_op    (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] state;
        logic [1:0] aluop;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       instr_done;
        logic       illegal_op;
    } outs_t;

    typedef struct {
        logic       rst_n;
        logic [5:0] op;
        logic [5:0] fn;
        logic       mr;
        outs_t      exp;
    } vec_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_BAD  = 6'b111111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_JR   = 6'b001000;

    // Hand-written expected output sets per state (and mem_ready where it matters).
    localparam outs_t E_F0   = '{state: 4'd0, mem_read: 1'b1, alu_src_b: 2'b01, default: '0};
    localparam outs_t E_F1   = '{state: 4'd0, mem_read: 1'b1, alu_src_b: 2'b01, ir_write: 1'b1, pc_write: 1'b1, default: '0};
    localparam outs_t E_DEC  = '{state: 4'd1, alu_src_b: 2'b11, default: '0};
    localparam outs_t E_DILL = '{state: 4'd1, alu_src_b: 2'b11, illegal_op: 1'b1, default: '0};
    localparam outs_t E_MA   = '{state: 4'd2, alu_src_a: 1'b1, alu_src_b: 2'b10, default: '0};
    localparam outs_t E_MR   = '{state: 4'd3, mem_read: 1'b1, iord: 1'b1, default: '0};
    localparam outs_t E_MWB  = '{state: 4'd4, reg_write: 1'b1, mem_to_reg: 1'b1, instr_done: 1'b1, default: '0};
    localparam outs_t E_MW0  = '{state: 4'd5, iord: 1'b1, mem_write: 1'b1, default: '0};
    localparam outs_t E_MW1  = '{state: 4'd5, iord: 1'b1, mem_write: 1'b1, instr_done: 1'b1, default: '0};
    localparam outs_t E_RX   = '{state: 4'd6, alu_src_a: 1'b1, aluop: 2'b10, default: '0};
    localparam outs_t E_RWB  = '{state: 4'd7, reg_write: 1'b1, reg_dst: 1'b1, instr_done: 1'b1, default: '0};
    localparam outs_t E_BR   = '{state: 4'd8, alu_src_a: 1'b1, aluop: 2'b01, pc_write_cond: 1'b1, pc_source: 2'b01, instr_done: 1'b1, default: '0};
    localparam outs_t E_J    = '{state: 4'd9, pc_write: 1'b1, pc_source: 2'b10, instr_done: 1'b1, default: '0};
    localparam outs_t E_IXA  = '{state: 4'd10, alu_src_a: 1'b1, alu_src_b: 2'b10, aluop: 2'b00, default: '0};
    localparam outs_t E_IXO  = '{state: 4'd10, alu_src_a: 1'b1, alu_src_b: 2'b10, aluop: 2'b11, default: '0};
    localparam outs_t E_IWB  = '{state: 4'd11, reg_write: 1'b1, instr_done: 1'b1, default: '0};
`ifdef MULTICYCLE_CONTROL_JR_EN
    localparam outs_t E_JR   = '{state: 4'd12, pc_write: 1'b1, pc_source: 2'b11, instr_done: 1'b1, default: '0};
`endif

    outs_t got;
    assign got = {state, aluop, pc_write, pc_write_cond, pc_source, iord, mem_read,
                  mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                  alu_src_b, instr_done, illegal_op};

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic mr, input outs_t exp);
        vecs.push_back('{rst_n: r, op: op, fn: fn, mr: mr, exp: exp});
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Run one instruction from FETCH, inserting `waits` not-ready cycles in the
    // memory data state, and count cycles up to and including instr_done.
    task automatic measure(input int id, input logic [5:0] op, input logic [5:0] fn,
                           input int waits, input int exp_cycles);
        int  cyc = 0;
        int  w   = waits;
        bit  done = 1'b0;
        rst_n  = 1'b1;
        opcode = op;
        funct  = fn;
        check("start_in_fetch", id, {28'd0, state}, 32'd0);
        while (!done && cyc < 40) begin
            if ((state == 4'd3 || state == 4'd5) && w > 0) begin
                mem_ready = 1'b0;
                w--;
            end else begin
                mem_ready = 1'b1;
            end
            #2;
            cyc++;
            if (instr_done === 1'b1) done = 1'b1;
            @(posedge clk);
            #1;
        end
        check("latency", id, done ? cyc : -1, exp_cycles);
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = 6'd0;
        funct     = 6'd0;
        mem_ready = 1'b0;

        // Reset then lw, zero wait states: 0,1,2,3,4
        add(1'b0, OP_LW,   6'd0,   1'b0, E_F0);
        add(1'b1, OP_LW,   6'd0,   1'b1, E_F1);
        add(1'b1, OP_LW,   6'd0,   1'b1, E_DEC);
        add(1'b1, OP_LW,   6'd0,   1'b1, E_MA);
        add(1'b1, OP_LW,   6'd0,   1'b1, E_MR);
        add(1'b1, OP_LW,   6'd0,   1'b1, E_MWB);
        // sw with three not-ready cycles in MEM_WRITE: 7 cycles total
        add(1'b1, OP_SW,   6'd0,   1'b1, E_F1);
        add(1'b1, OP_SW,   6'd0,   1'b1, E_DEC);
        add(1'b1, OP_SW,   6'd0,   1'b1, E_MA);
        add(1'b1, OP_SW,   6'd0,   1'b0, E_MW0);
        add(1'b1, OP_SW,   6'd0,   1'b0, E_MW0);
        add(1'b1, OP_SW,   6'd0,   1'b0, E_MW0);
        add(1'b1, OP_SW,   6'd0,   1'b1, E_MW1);
        // ori with a FETCH wait; mem_ready low elsewhere must be ignored
        add(1'b1, OP_ORI,  6'd0,   1'b0, E_F0);
        add(1'b1, OP_ORI,  6'd0,   1'b1, E_F1);
        add(1'b1, OP_ORI,  6'd0,   1'b0, E_DEC);
        add(1'b1, OP_ORI,  6'd0,   1'b0, E_IXO);
        add(1'b1, OP_ORI,  6'd0,   1'b0, E_IWB);
        // addi
        add(1'b1, OP_ADDI, 6'd0,   1'b1, E_F1);
        add(1'b1, OP_ADDI, 6'd0,   1'b1, E_DEC);
        add(1'b1, OP_ADDI, 6'd0,   1'b1, E_IXA);
        add(1'b1, OP_ADDI, 6'd0,   1'b1, E_IWB);
        // beq, then j
        add(1'b1, OP_BEQ,  6'd0,   1'b1, E_F1);
        add(1'b1, OP_BEQ,  6'd0,   1'b1, E_DEC);
        add(1'b1, OP_BEQ,  6'd0,   1'b0, E_BR);
        add(1'b1, OP_J,    6'd0,   1'b1, E_F1);
        add(1'b1, OP_J,    6'd0,   1'b1, E_DEC);
        add(1'b1, OP_J,    6'd0,   1'b1, E_J);
        // illegal opcode: one DECODE cycle with illegal_op, back to FETCH
        add(1'b1, OP_BAD,  6'd0,   1'b1, E_F1);
        add(1'b1, OP_BAD,  6'd0,   1'b1, E_DILL);
        add(1'b1, OP_BAD,  6'd0,   1'b0, E_F0);
        // R-type add
        add(1'b1, OP_R,    FN_ADD, 1'b1, E_F1);
        add(1'b1, OP_R,    FN_ADD, 1'b1, E_DEC);
        add(1'b1, OP_R,    FN_ADD, 1'b0, E_RX);
        add(1'b1, OP_R,    FN_ADD, 1'b0, E_RWB);
        // lw with two MEM_READ waits
        add(1'b1, OP_LW,   6'd0,   1'b1, E_F1);
        add(1'b1, OP_LW,   6'd0,   1'b1, E_DEC);
        add(1'b1, OP_LW,   6'd0,   1'b1, E_MA);
        add(1'b1, OP_LW,   6'd0,   1'b0, E_MR);
        add(1'b1, OP_LW,   6'd0,   1'b0, E_MR);
        add(1'b1, OP_LW,   6'd0,   1'b1, E_MR);
        add(1'b1, OP_LW,   6'd0,   1'b1, E_MWB);
        // jr: JR state with the option, plain R-type path without it
        add(1'b1, OP_R,    FN_JR,  1'b1, E_F1);
        add(1'b1, OP_R,    FN_JR,  1'b1, E_DEC);
`ifdef MULTICYCLE_CONTROL_JR_EN
        add(1'b1, OP_R,    FN_JR,  1'b1, E_JR);
`else
        add(1'b1, OP_R,    FN_JR,  1'b1, E_RX);
        add(1'b1, OP_R,    FN_JR,  1'b1, E_RWB);
`endif
        // reset during a MEM_READ wait: back to FETCH, no register write
        add(1'b1, OP_LW,   6'd0,   1'b1, E_F1);
        add(1'b1, OP_LW,   6'd0,   1'b1, E_DEC);
        add(1'b1, OP_LW,   6'd0,   1'b1, E_MA);
        add(1'b1, OP_LW,   6'd0,   1'b0, E_MR);
        add(1'b0, OP_LW,   6'd0,   1'b0, E_MR);
        add(1'b1, OP_LW,   6'd0,   1'b0, E_F0);
        add(1'b1, OP_LW,   6'd0,   1'b0, E_F0);
        // reset during a MEM_WRITE wait: write strobe dropped after the edge
        add(1'b1, OP_SW,   6'd0,   1'b1, E_F1);
        add(1'b1, OP_SW,   6'd0,   1'b1, E_DEC);
        add(1'b1, OP_SW,   6'd0,   1'b1, E_MA);
        add(1'b0, OP_SW,   6'd0,   1'b0, E_MW0);
        add(1'b1, OP_SW,   6'd0,   1'b0, E_F0);

        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            rst_n     = vecs[i].rst_n;
            opcode    = vecs[i].op;
            funct     = vecs[i].fn;
            mem_ready = vecs[i].mr;
            #2;
            check("vec_outputs", i, {10'd0, got}, {10'd0, vecs[i].exp});
            @(posedge clk);
            #1;
        end

        // Latency with wait states in the memory data phase
        measure(0, OP_LW,   6'd0,   0, 5);
        measure(1, OP_LW,   6'd0,   2, 7);
        measure(2, OP_SW,   6'd0,   0, 4);
        measure(3, OP_SW,   6'd0,   3, 7);
        measure(4, OP_R,    FN_ADD, 0, 4);
        measure(5, OP_ORI,  6'd0,   0, 4);
        measure(6, OP_ADDI, 6'd0,   1, 4);
        measure(7, OP_BEQ,  6'd0,   0, 3);
        measure(8, OP_J,    6'd0,   0, 3);
`ifdef MULTICYCLE_CONTROL_JR_EN
        measure(9, OP_R,    FN_JR,  0, 3);
`else
        measure(9, OP_R,    FN_JR,  0, 4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset. Ports are listed below, clock and reset first.
REQ-002 Port list:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- opcode  input  6  instruction register bits [31:26].
- funct  input  6  instruction register bits [5:0].
- mem_ready  input  1  memory completes the current access this cycle.
- aluop  output  2  to ALU control: 00 add, 01 sub, 10 use funct, 11 or.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load if ALU zero.
- pc_source  output  2  PC mux: 00 ALU, 01 ALUOut, 10 jump target, 11 register rs.
- iord  output  1  memory address select: 0 PC, 1 ALUOut.
- mem_read  output  1  memory read.
- mem_write  output  1  memory write.
- ir_write  output  1  instruction register load.
- mem_to_reg  output  1  register write-data select: 1 MDR.
- reg_dst  output  1  destination register select: 1 rd, 0 rt.
- reg_write  output  1  register file write.
- alu_src_a  output  1  ALU A select: 0 PC, 1 A.
- alu_src_b  output  2  ALU B select: 00 B, 01 const 4, 10 sign-extended immediate, 11 shifted immediate.
- state  output  4  current state encoding.
- instr_done  output  1  last cycle of the instruction.
- illegal_op  output  1  unrecognised opcode seen in DECODE.

Function
REQ-003 The block SHALL be a Moore FSM: outputs decode from the state register, gated by mem_ready only where stated.
REQ-004 State encodings SHALL be: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11, JR 12. Codes 13-15 SHALL go to FETCH on the next edge.
REQ-005 FETCH SHALL drive mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, aluop=00, pc_source=00, with ir_write=pc_write=mem_ready. It SHALL stay in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-006 DECODE SHALL drive alu_src_a=0, alu_src_b=11, aluop=00. Next state by opcode:
- 000000 → R_EXEC
- 100011 or 101011 → MEM_ADDR
- 000100 → BRANCH
- 000010 → JUMP
- 001000 or 001101 → I_EXEC
- any other opcode → FETCH, with illegal_op=1 during that DECODE cycle.
REQ-007 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10, aluop=00, and go to MEM_READ for opcode 100011 or MEM_WRITE for opcode 101011.
REQ-008 MEM_READ SHALL drive mem_read=1, iord=1, hold while mem_ready=0, then go to MEM_WB. MEM_WB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0, then go to FETCH.
REQ-009 MEM_WRITE SHALL drive iord=1, mem_write=1, hold while mem_ready=0, then go to FETCH.
REQ-010 R_EXEC SHALL drive alu_src_a=1, alu_src_b=00, aluop=10, then go to R_WB. R_WB SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0, then go to FETCH.
REQ-011 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, aluop=01, pc_write_cond=1, pc_source=01, then go to FETCH.
REQ-012 JUMP SHALL drive pc_write=1, pc_source=10, then go to FETCH.
REQ-013 I_EXEC SHALL drive alu_src_a=1, alu_src_b=10, and aluop=00 for opcode 001000 or aluop=11 for opcode 001101, then go to I_WB. I_WB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0, then go to FETCH.
REQ-014 JR SHALL drive pc_write=1, pc_source=11, then go to FETCH.
REQ-015 All outputs not listed for a state SHALL be 0.
REQ-016 instr_done SHALL be 1 in MEM_WB, R_WB, BRANCH, JUMP, I_WB and JR, and in MEM_WRITE when mem_ready=1.
REQ-017 With zero wait states, latency SHALL be: lw 5 cycles; sw, R-type and addi/ori 4 cycles; beq, j and jr 3 cycles. Each cycle mem_ready=0 in a wait state adds one cycle.
REQ-018 mem_ready SHALL be ignored in all states other than FETCH, MEM_READ and MEM_WRITE.

Reset
REQ-019 On a rising edge with rst_n=0, state SHALL become FETCH regardless of the current state or a pending memory wait.
REQ-020 Post-reset outputs SHALL be the FETCH values: mem_read=1, alu_src_b=01, all other outputs 0 with mem_ready=0, and state=0.
REQ-021 An instruction interrupted by reset SHALL be abandoned with no write strobe asserted after the reset edge.

Configuration
REQ-022 With macro MULTICYCLE_CONTROL_JR_EN defined, DECODE with opcode 000000 and funct 001000 SHALL go to JR.
REQ-023 Without MULTICYCLE_CONTROL_JR_EN, funct SHALL be ignored, the JR state SHALL not exist, and jr SHALL follow the R_EXEC/R_WB path.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset then lw (opcode 100011), mem_ready always 1 → states 0,1,2,3,4; reg_write=1 and mem_to_reg=1 in state 4; instr_done=1 once.
- sw (101011) with mem_ready held 0 for 3 cycles in MEM_WRITE → mem_write=1 for 4 cycles; instr_done=1 only on the last cycle; total 7 cycles.
- ori (001101) → aluop=11 in I_EXEC; addi (001000) → aluop=00; both write with reg_dst=0.
- Opcode 111111 → illegal_op=1 for one cycle, then FETCH with no reg_write, mem_write or pc_write.
- R-type funct 001000 → with macro: states 0,1,12 and pc_source=11; without macro: states 0,1,6,7.
- rst_n=0 during MEM_READ wait → next state 0, mem_read=1, iord=0, reg_write never asserted.
